// File: rtl/lower_resp_pkg.sv
// Shared types and helpers for the lower_responder request/response path.
package lower_resp_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_B    = 2'b01,
    KIND_A    = 2'b10,
    KIND_AB   = 2'b11
  } kind_t;

  localparam int unsigned LATENCY_MAX = 8;
  localparam int unsigned DEPTH_MAX   = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lower_resp_fifo.sv
// Synchronous-reset pointer FIFO; pointers carry a wrap bit to tell full from empty.
module lower_resp_fifo
  import lower_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lower_responder.sv
// Far-end responder: classifies requests, delays them LATENCY stages, queues and hands them out.
// Optional drop counter output enabled by LOWER_RESPONDER_DROPCNT_EN.
module lower_responder
  import lower_resp_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lower_ina,
  input  logic             lower_inb,
  output logic             lower_out,
  output logic [1:0]       resp_kind,
  input  logic             resp_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_overflow
`ifdef LOWER_RESPONDER_DROPCNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  kind_t            stage [LATENCY];
  logic             stage_busy;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;

  // Kind 00 travels as a bubble, so stage validity is simply kind != NONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= KIND_NONE;
    end else begin
      stage[0] <= kind_t'({lower_ina, lower_inb});
      for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign push_req = (stage[LATENCY-1] != KIND_NONE);
  assign pop      = !fifo_empty && resp_ready;
  assign drop     = push_req && fifo_full && !pop;

  lower_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (stage[LATENCY-1]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    stage_busy = 1'b0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      if (stage[i] != KIND_NONE) stage_busy = 1'b1;
    end
  end

  assign lower_out = !fifo_empty;
  assign resp_kind = fifo_empty ? KIND_NONE : fifo_rdata;
  assign occupancy = fifo_count;
  assign busy      = stage_busy || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

`ifdef LOWER_RESPONDER_DROPCNT_EN
  // A drop in the clear cycle restarts the count at 1 rather than 0.
  always_ff @(posedge clk) begin
    if (!rst_n)                 drop_cnt <= '0;
    else if (drop) begin
      if (clr_overflow)         drop_cnt <= 8'd1;
      else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_overflow)  drop_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_lower_responder.sv
// Self-checking bench for lower_responder with a queue-based reference model.
module tb_lower_responder;

  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 3;

  logic             clk;
  logic             rst_n;
  logic             lower_ina;
  logic             lower_inb;
  logic             lower_out;
  logic [1:0]       resp_kind;
  logic             resp_ready;
  logic [CNT_W-1:0] occupancy;
  logic             busy;
  logic             overflow;
  logic             clr_overflow;
`ifdef LOWER_RESPONDER_DROPCNT_EN
  logic [7:0]       drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  lower_responder #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lower_ina    (lower_ina),
    .lower_inb    (lower_inb),
    .lower_out    (lower_out),
    .resp_kind    (resp_kind),
    .resp_ready   (resp_ready),
    .occupancy    (occupancy),
    .busy         (busy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef LOWER_RESPONDER_DROPCNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: requests in flight carry the edge at which they reach the queue.
  typedef struct {
    logic [1:0]  kind;
    int unsigned due;
  } flight_t;

  flight_t     m_flight[$];
  logic [1:0]  m_q[$];
  logic        m_ovf   = 1'b0;
  int          m_dcnt  = 0;
  int unsigned edge_n  = 0;

  always @(posedge clk) begin
    bit      m_pop;
    bit      m_arr;
    bit      m_drop;
    int      pre_size;
    flight_t f;
    edge_n++;
    if (!rst_n) begin
      m_flight.delete();
      m_q.delete();
      m_ovf  = 1'b0;
      m_dcnt = 0;
    end else begin
      pre_size = m_q.size();
      m_pop    = (pre_size > 0) && resp_ready;
      m_arr    = 1'b0;
      m_drop   = 1'b0;
      if (m_flight.size() > 0 && m_flight[0].due == edge_n) begin
        f     = m_flight.pop_front();
        m_arr = 1'b1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_arr) begin
        if (pre_size < DEPTH || m_pop) m_q.push_back(f.kind);
        else m_drop = 1'b1;
      end
      if (m_drop) begin
        m_ovf  = 1'b1;
        m_dcnt = clr_overflow ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
      end else if (clr_overflow) begin
        m_ovf  = 1'b0;
        m_dcnt = 0;
      end
      if (lower_ina || lower_inb) begin
        f.kind = {lower_ina, lower_inb};
        f.due  = edge_n + LATENCY;
        m_flight.push_back(f);
      end
    end
  end

  task automatic idle(input int n);
    lower_ina    = 1'b0;
    lower_inb    = 1'b0;
    clr_overflow = 1'b0;
    resp_ready   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (lower_out !== 1'b0 || occupancy !== '0 || busy !== 1'b0 || overflow !== 1'b0 ||
          resp_kind !== 2'b00) begin
        tests_failed++;
        $display("FAIL reset_hold: out=%b occ=%0d busy=%b ovf=%b kind=%b, required all zero",
                 lower_out, occupancy, busy, overflow, resp_kind);
      end
    end
    lower_ina = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < LATENCY + 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (lower_out !== 1'b0 || occupancy !== '0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_release: out=%b occ=%0d busy=%b, required 0 0 0",
                 lower_out, occupancy, busy);
      end
    end
  endtask

  task automatic test_latency();
    logic exp_out;
    idle(LATENCY + DEPTH + 2);
    lower_ina = 1'b1;
    lower_inb = 1'b0;
    @(negedge clk);
    lower_ina = 1'b0;
    for (int i = 1; i <= LATENCY + 3; i++) begin
      exp_out = (i == LATENCY + 1);
      tests_run++;
      if (lower_out !== exp_out || resp_kind !== (exp_out ? 2'b10 : 2'b00)) begin
        tests_failed++;
        $display("FAIL latency_cycle%0d: out=%b kind=%b, required out=%b kind=%b",
                 i, lower_out, resp_kind, exp_out, exp_out ? 2'b10 : 2'b00);
      end
      if (i >= LATENCY + 2) begin
        tests_run++;
        if (occupancy !== '0) begin
          tests_failed++;
          $display("FAIL latency_drain%0d: occ=%0d, required 0", i, occupancy);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ordering();
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
    idle(LATENCY + DEPTH + 2);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {lower_ina, lower_inb} = seq[i];
      @(negedge clk);
    end
    lower_ina = 1'b0;
    lower_inb = 1'b0;
    repeat (LATENCY) @(negedge clk);
    tests_run++;
    if (occupancy !== 3'd3) begin
      tests_failed++;
      $display("FAIL order_occupancy: occ=%0d, required 3", occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (lower_out !== 1'b1 || resp_kind !== seq[0]) begin
        tests_failed++;
        $display("FAIL order_stall%0d: out=%b kind=%b, required 1 %b", i, lower_out, resp_kind, seq[0]);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (lower_out !== 1'b1 || resp_kind !== seq[i]) begin
        tests_failed++;
        $display("FAIL order_pop%0d: out=%b kind=%b, required 1 %b", i, lower_out, resp_kind, seq[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (lower_out !== 1'b0 || occupancy !== '0) begin
      tests_failed++;
      $display("FAIL order_empty: out=%b occ=%0d, required 0 0", lower_out, occupancy);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] sent [6];
    idle(LATENCY + DEPTH + 2);
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sent[i] = 2'($urandom_range(3, 1));
      {lower_ina, lower_inb} = sent[i];
      @(negedge clk);
    end
    lower_ina = 1'b0;
    lower_inb = 1'b0;
    repeat (LATENCY) @(negedge clk);
    tests_run++;
    if (occupancy !== 3'd4 || overflow !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow_state: occ=%0d ovf=%b busy=%b, required 4 1 1", occupancy, overflow, busy);
    end
`ifdef LOWER_RESPONDER_DROPCNT_EN
    tests_run++;
    if (drop_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL overflow_dropcnt: drop_cnt=%0d, required 2", drop_cnt);
    end
`endif
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lower_out !== 1'b1 || resp_kind !== sent[i]) begin
        tests_failed++;
        $display("FAIL overflow_kept%0d: out=%b kind=%b, required 1 %b", i, lower_out, resp_kind, sent[i]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (lower_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_empty: out=%b, required 0", lower_out);
    end
  endtask

  task automatic test_full_push_pop();
    bit reached;
    clr_overflow = 1'b1;
    @(negedge clk);
    idle(LATENCY + DEPTH + 2);
    resp_ready = 1'b0;
    reached    = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (occupancy === 3'(DEPTH)) reached = 1'b1;
      else begin
        {lower_ina, lower_inb} = 2'($urandom_range(3, 1));
        @(negedge clk);
      end
    end
    tests_run++;
    if (!reached) begin
      tests_failed++;
      $display("FAIL full_reach: occ=%0d, required %0d within 20 cycles", occupancy, DEPTH);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {lower_ina, lower_inb} = 2'($urandom_range(3, 1));
      @(negedge clk);
      tests_run++;
      if (occupancy !== 3'(DEPTH) || overflow !== 1'b0 || lower_out !== 1'b1 ||
          resp_kind !== m_q[0]) begin
        tests_failed++;
        $display("FAIL full_pushpop%0d: occ=%0d ovf=%b out=%b kind=%b, required %0d 0 1 %b",
                 i, occupancy, overflow, lower_out, resp_kind, DEPTH, m_q[0]);
      end
    end
    idle(LATENCY + DEPTH + 2);
  endtask

  task automatic test_clear();
    bit seen;
    resp_ready = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      {lower_ina, lower_inb} = 2'($urandom_range(3, 1));
      @(negedge clk);
      if (overflow === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL clear_setup: ovf=%b, required 1 within 20 cycles", overflow);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_with_drop: ovf=%b, required 1", overflow);
    end
`ifdef LOWER_RESPONDER_DROPCNT_EN
    tests_run++;
    if (drop_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL clear_with_drop_cnt: drop_cnt=%0d, required 1", drop_cnt);
    end
`endif
    lower_ina = 1'b0;
    lower_inb = 1'b0;
    repeat (LATENCY + 1) @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_no_drop: ovf=%b, required 0", overflow);
    end
`ifdef LOWER_RESPONDER_DROPCNT_EN
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL clear_no_drop_cnt: drop_cnt=%0d, required 0", drop_cnt);
    end
`endif
    idle(LATENCY + DEPTH + 2);
  endtask

  task automatic test_random();
    logic [1:0] exp_kind;
    logic       exp_busy;
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(63) != 0);
      lower_ina    = 1'($urandom_range(1));
      lower_inb    = 1'($urandom_range(1));
      resp_ready   = ($urandom_range(3) != 0);
      clr_overflow = ($urandom_range(7) == 0);
      @(negedge clk);
      exp_kind = (m_q.size() > 0) ? m_q[0] : 2'b00;
      exp_busy = (m_flight.size() > 0) || (m_q.size() > 0);
      tests_run++;
      if (lower_out !== (m_q.size() > 0) || resp_kind !== exp_kind ||
          occupancy !== CNT_W'(m_q.size()) || busy !== exp_busy || overflow !== m_ovf) begin
        tests_failed++;
        $display("FAIL random%0d: out=%b kind=%b occ=%0d busy=%b ovf=%b, required %b %b %0d %b %b",
                 i, lower_out, resp_kind, occupancy, busy, overflow,
                 m_q.size() > 0, exp_kind, m_q.size(), exp_busy, m_ovf);
      end
`ifdef LOWER_RESPONDER_DROPCNT_EN
      tests_run++;
      if (drop_cnt !== 8'(m_dcnt)) begin
        tests_failed++;
        $display("FAIL random_dropcnt%0d: drop_cnt=%0d, required %0d", i, drop_cnt, m_dcnt);
      end
`endif
    end
    rst_n = 1'b1;
    idle(LATENCY + DEPTH + 2);
  endtask

  initial begin
    rst_n        = 1'b0;
    lower_ina    = 1'b1;
    lower_inb    = 1'b0;
    resp_ready   = 1'b0;
    clr_overflow = 1'b0;
    test_reset();
    test_latency();
    test_ordering();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
